set_assoc_dcache_ctrl: RTL and testbench
========================================

# set_assoc_dcache_ctrl

Clocked, parametrised set-associative data-cache tag controller for the trace-driven cache simulator. It accepts trace commands (read, write, invalidate, clear, print) through a valid/ready handshake and maintains per-way tag, valid, dirty and true-LRU state. It issues line requests to the next-level cache and keeps hit/miss/read/write statistics for the statistics module. It generalises the combinational data cache to configurable sets, ways and line size, with real miss/eviction sequencing.

## Interface
- `ADDR_W`, 32: trace address width.
- `OFFSET_BITS`, 6: log2 line size in bytes.
- `INDEX_BITS`, 14: log2 number of sets (16K).
- `WAYS`, 4: associativity; power of two, 2..16.
- `TAG_BITS`: derived, ADDR_W-INDEX_BITS-OFFSET_BITS; not user-set.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: controller can accept a command.
- `cmd` in 4: trace code. 0 READ, 1 WRITE, 3 INVALIDATE, 8 CLEAR, 9 PRINT. Any other code is a no-op.
- `cmd_addr` in ADDR_W: trace address.
- `rsp_valid` out 1: one-cycle pulse on command completion.
- `rsp_hit` out 1: completed READ/WRITE hit; qualified by rsp_valid.
- `mem_req_valid` out 1: next-level request.
- `mem_req_we` out 1: 1 = line write, 0 = line read.
- `mem_req_addr` out ADDR_W-OFFSET_BITS: line address.
- `mem_req_ready` in 1: next level accepts the request.
- `hit_cnt`, `miss_cnt`, `read_cnt`, `write_cnt` out 32 each: statistics counters.

## Operation
- **Address split:**
  - tag = addr[ADDR_W-1 : INDEX_BITS+OFFSET_BITS]
  - index = addr[INDEX_BITS+OFFSET_BITS-1 : OFFSET_BITS]
- **State storage:**
  - valid, dirty and age are in flops and are resettable.
  - Tags are in RAM; tag contents are don't-care while the line is invalid.
- **LRU:**
  - Each way holds an age of log2(WAYS) bits; ages within a set are always a permutation of 0..WAYS-1.
  - On access to way w with old age a, age[w] becomes 0, and every way with age below a is incremented.
  - Reset/CLEAR sets age[w]=w.
- **Victim selection:** the lowest-index invalid way; if all ways are valid, the way with age WAYS-1.
- **FSM states:** IDLE, LOOKUP, EVICT, FILL, WTHRU, RESP. cmd_ready=1 only in IDLE.
- **IDLE:** on cmd_valid&&cmd_ready, latch cmd/cmd_addr and go to LOOKUP.
- **LOOKUP** compares all ways in parallel.
  - READ hit: LRU update, then RESP.
  - READ miss: go to EVICT if the victim is valid and dirty, else FILL.
  - WRITE: see Configuration.
  - INVALIDATE: clear valid and dirty of the matching way (no writeback, no LRU change), then RESP; a miss is a silent RESP.
  - CLEAR: clear all valid/dirty, reset ages, zero all four counters, then RESP.
  - PRINT and other codes: RESP with no state change.
- **EVICT:** mem_req_valid=1, we=1, addr={victim tag,index}; on mem_req_ready go to FILL.
- **FILL:** mem_req_valid=1, we=0, addr={tag,index}.
  - On mem_req_ready, install the tag in the victim way: valid=1, dirty per write policy, LRU update.
  - Then go to RESP.
- **WTHRU:** mem_req_valid=1, we=1, addr={tag,index}; on mem_req_ready go to RESP.
- **RESP:** rsp_valid=1 for one cycle, then IDLE.
- **Counters:**
  - READ increments read_cnt; WRITE increments write_cnt.
  - Each READ/WRITE increments exactly one of hit_cnt/miss_cnt, in the LOOKUP cycle.
  - Counters saturate at 32'hFFFF_FFFF.
- **mem_req holding:** mem_req_addr and mem_req_we hold stable while mem_req_valid=1 and mem_req_ready=0.

## Timing
- **Reset values:** cmd_ready=1, rsp_valid=0, rsp_hit=0, mem_req_valid=0, mem_req_we=0, mem_req_addr=0, all counters 0, FSM=IDLE, all valid/dirty=0, ages reset.
- **rst has priority in any state**, including mid-miss. An outstanding mem_req_valid drops the next cycle, and no fill is installed.
- **Hit latency:** command accepted at edge T; LOOKUP in cycle T+1; rsp_valid in cycle T+2; cmd_ready=1 again in cycle T+3.
- **Miss latency:** 2 + (cycles waiting for mem_req_ready per request) + 1.
  - With mem_req_ready tied to 1: a clean READ miss asserts rsp_valid in cycle T+3.
  - A dirty-eviction READ miss asserts rsp_valid in cycle T+4.
- **Handshake:** one request per state. mem_req_ready seen in the same cycle as mem_req_valid completes the request.
- **Counter visibility:** updates are visible the cycle after LOOKUP; CLEAR zeroes them the cycle after LOOKUP.

## Configuration
- **`DCACHE_WRITEBACK_EN` defined:** write-back, write-allocate.
  - WRITE hit: set dirty, LRU update, RESP; no mem request.
  - WRITE miss: treated as a READ miss, and the filled line is installed dirty=1.
- **`DCACHE_WRITEBACK_EN` undefined:** write-through, no-write-allocate. The dirty bits and the EVICT state are not built.
  - WRITE hit: LRU update, then WTHRU.
  - WRITE miss: no allocation, no LRU change; go to WTHRU.

## Test plan
- **Cold read then re-read:** after rst, READ 0x0000_0040 then READ 0x0000_0040 with mem_req_ready=1.
  - First read: FILL request at addr 0x1, rsp_hit=0.
  - Second read: rsp_hit=1 at T+2.
  - Counters: hit=1, miss=1, read=2.
- **LRU eviction (WAYS=4):** READ five distinct tags to index 0 (0x0010_0000, 0x0020_0000, 0x0030_0000, 0x0040_0000, 0x0050_0000), then READ 0x0010_0000 -> miss, because the first tag was the victim; final miss_cnt=6.
- **Dirty eviction (WRITEBACK_EN):** WRITE four tags to index 0, then READ a fifth tag -> EVICT we=1 with addr={tag 0x001,index 0}, followed by FILL we=0.
- **INVALIDATE:** READ 0x0000_0080, INVALIDATE 0x0000_0080, READ 0x0000_0080 -> the final read misses; the invalidate changes no counter.
- **Stalled memory and reset:**
  - Hold mem_req_ready=0 for 5 cycles during FILL -> mem_req_addr stays stable and cmd_ready=0.
  - Assert rst mid-FILL -> next cycle mem_req_valid=0, cmd_ready=1, counters 0.
- **CLEAR and no-ops:** CLEAR after traffic -> counters 0 and the next READ misses. PRINT and cmd=4'd5 -> rsp_valid pulse, no counter change.

Source files
------------

// File: rtl/set_assoc_dcache_ctrl.sv
// set_assoc_dcache_ctrl: set-associative data-cache tag controller.
// Accepts trace commands (READ/WRITE/INVALIDATE/CLEAR/PRINT) over a valid/ready
// handshake, keeps per-way tag/valid/(dirty)/true-LRU state, sequences line
// requests to the next level and maintains hit/miss/read/write counters.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd/cmd_addr   command handshake and payload
//   rsp_valid, rsp_hit            one-cycle completion pulse and hit flag
//   mem_req_valid/we/addr/ready   next-level line request
//   hit_cnt/miss_cnt/read_cnt/write_cnt   saturating statistics
// Build option: define DCACHE_WRITEBACK_EN for write-back/write-allocate;
// otherwise write-through/no-write-allocate (no dirty bits, no EVICT state).
module set_assoc_dcache_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned OFFSET_BITS = 6,
  parameter int unsigned INDEX_BITS  = 14,
  parameter int unsigned WAYS        = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [3:0]                    cmd,
  input  logic [ADDR_W-1:0]             cmd_addr,
  output logic                          rsp_valid,
  output logic                          rsp_hit,
  output logic                          mem_req_valid,
  output logic                          mem_req_we,
  output logic [ADDR_W-OFFSET_BITS-1:0] mem_req_addr,
  input  logic                          mem_req_ready,
  output logic [31:0]                   hit_cnt,
  output logic [31:0]                   miss_cnt,
  output logic [31:0]                   read_cnt,
  output logic [31:0]                   write_cnt
);
  localparam int unsigned TAG_BITS = ADDR_W - INDEX_BITS - OFFSET_BITS;
  localparam int unsigned SETS     = 1 << INDEX_BITS;
  localparam int unsigned WAY_W    = $clog2(WAYS);
  localparam int unsigned LINE_W   = ADDR_W - OFFSET_BITS;

  localparam logic [3:0] CMD_READ  = 4'd0;
  localparam logic [3:0] CMD_WRITE = 4'd1;
  localparam logic [3:0] CMD_INVAL = 4'd3;
  localparam logic [3:0] CMD_CLEAR = 4'd8;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
`ifdef DCACHE_WRITEBACK_EN
    EVICT,
`endif
    FILL,
    WTHRU,
    RESP
  } state_t;

  typedef logic [WAYS-1:0][WAY_W-1:0] age_set_t;

  // Reset ordering of ages: way w has age w.
  function automatic age_set_t age_init();
    age_set_t a;
    for (int w = 0; w < WAYS; w++) a[w] = WAY_W'(w);
    return a;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_t                state_q, state_d, miss_state;
  logic [3:0]            cmd_q;
  logic [TAG_BITS-1:0]   tag_q;
  logic [INDEX_BITS-1:0] idx_q;
  logic [WAY_W-1:0]      victim_q;
  logic                  hit_q;

  logic [WAYS-1:0]                valid_q [SETS];
`ifdef DCACHE_WRITEBACK_EN
  logic [WAYS-1:0]                dirty_q [SETS];
  logic                           mark_dirty;
`endif
  age_set_t                       age_q   [SETS];
  logic [WAYS-1:0][TAG_BITS-1:0]  tag_ram [SETS];

  // Byte offset within a line does not affect tag state.
  logic unused_offset;
  assign unused_offset = ^cmd_addr[OFFSET_BITS-1:0];

  logic [WAYS-1:0]  set_valid;
  age_set_t         set_age, lru_age;
  logic             hit, found_free, is_rw;
  logic [WAY_W-1:0] hit_way, victim_way, lru_way;

  // Parallel tag compare, victim choice and LRU aging for the latched set.
  always_comb begin
    set_valid  = valid_q[idx_q];
    set_age    = age_q[idx_q];
    hit        = 1'b0;
    hit_way    = '0;
    victim_way = '0;
    found_free = 1'b0;
    lru_age    = set_age;
    for (int w = 0; w < WAYS; w++) begin
      if (set_valid[w] && (tag_ram[idx_q][w] == tag_q)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!found_free && !set_valid[w]) begin
        found_free = 1'b1;
        victim_way = WAY_W'(w);
      end
    end
    if (!found_free) begin
      for (int w = 0; w < WAYS; w++) begin
        if (set_age[w] == WAY_W'(WAYS - 1)) victim_way = WAY_W'(w);
      end
    end
    lru_way = (state_q == FILL) ? victim_q : hit_way;
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == lru_way)             lru_age[w] = '0;
      else if (set_age[w] < set_age[lru_way]) lru_age[w] = set_age[w] + WAY_W'(1);
      else                                  lru_age[w] = set_age[w];
    end
  end

  logic             lru_upd, inv_hit, install, clear_all;
  logic             cmd_ready_d, rsp_valid_d, rsp_hit_d, req_valid_d, req_we_d;
  logic [LINE_W-1:0] req_addr_d;

  // Next-state, update strobes and next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    lru_upd   = 1'b0;
    inv_hit   = 1'b0;
    install   = 1'b0;
    clear_all = 1'b0;
`ifdef DCACHE_WRITEBACK_EN
    mark_dirty = 1'b0;
    miss_state = (set_valid[victim_way] && dirty_q[idx_q][victim_way]) ? EVICT : FILL;
`else
    miss_state = FILL;
`endif
    is_rw = (cmd_q == CMD_READ) || (cmd_q == CMD_WRITE);

    case (state_q)
      IDLE: if (cmd_valid) state_d = LOOKUP;
      LOOKUP: begin
        state_d = RESP;
        if (cmd_q == CMD_INVAL) begin
          inv_hit = hit;
        end else if (cmd_q == CMD_CLEAR) begin
          clear_all = 1'b1;
        end else if (cmd_q == CMD_READ) begin
          if (hit) lru_upd = 1'b1;
          else     state_d = miss_state;
        end else if (cmd_q == CMD_WRITE) begin
`ifdef DCACHE_WRITEBACK_EN
          if (hit) begin
            lru_upd    = 1'b1;
            mark_dirty = 1'b1;
          end else begin
            state_d = miss_state;
          end
`else
          lru_upd = hit;
          state_d = WTHRU;
`endif
        end
      end
`ifdef DCACHE_WRITEBACK_EN
      EVICT: if (mem_req_ready) state_d = FILL;
`endif
      FILL: if (mem_req_ready) begin
        install = 1'b1;
        lru_upd = 1'b1;
        state_d = RESP;
      end
      WTHRU: if (mem_req_ready) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    rsp_hit_d   = rsp_valid_d && ((state_q == LOOKUP) ? (hit && is_rw) : hit_q);
`ifdef DCACHE_WRITEBACK_EN
    req_valid_d = (state_d == FILL) || (state_d == WTHRU) || (state_d == EVICT);
`else
    req_valid_d = (state_d == FILL) || (state_d == WTHRU);
`endif
    // Request fields load only on entry to a request state, so they hold while stalled.
    req_we_d   = mem_req_we;
    req_addr_d = mem_req_addr;
    if (state_d != state_q) begin
      case (state_d)
`ifdef DCACHE_WRITEBACK_EN
        EVICT: begin
          req_we_d   = 1'b1;
          req_addr_d = {tag_ram[idx_q][victim_way], idx_q};
        end
`endif
        FILL: begin
          req_we_d   = 1'b0;
          req_addr_d = {tag_q, idx_q};
        end
        WTHRU: begin
          req_we_d   = 1'b1;
          req_addr_d = {tag_q, idx_q};
        end
        default: ;
      endcase
    end
  end

  // State, outputs, counters and per-way valid/dirty/age flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_hit       <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      hit_cnt       <= '0;
      miss_cnt      <= '0;
      read_cnt      <= '0;
      write_cnt     <= '0;
      cmd_q         <= '0;
      tag_q         <= '0;
      idx_q         <= '0;
      victim_q      <= '0;
      hit_q         <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
`ifdef DCACHE_WRITEBACK_EN
        dirty_q[s] <= '0;
`endif
        age_q[s]   <= age_init();
      end
    end else begin
      state_q       <= state_d;
      cmd_ready     <= cmd_ready_d;
      rsp_valid     <= rsp_valid_d;
      rsp_hit       <= rsp_hit_d;
      mem_req_valid <= req_valid_d;
      mem_req_we    <= req_we_d;
      mem_req_addr  <= req_addr_d;

      if (state_q == IDLE && cmd_valid) begin
        cmd_q <= cmd;
        tag_q <= cmd_addr[ADDR_W-1 -: TAG_BITS];
        idx_q <= cmd_addr[INDEX_BITS+OFFSET_BITS-1 : OFFSET_BITS];
      end

      if (state_q == LOOKUP) begin
        victim_q <= victim_way;
        hit_q    <= hit && is_rw;
        if (clear_all) begin
          hit_cnt   <= '0;
          miss_cnt  <= '0;
          read_cnt  <= '0;
          write_cnt <= '0;
        end else begin
          if (cmd_q == CMD_READ)  read_cnt  <= sat_inc(read_cnt);
          if (cmd_q == CMD_WRITE) write_cnt <= sat_inc(write_cnt);
          if (is_rw && hit)       hit_cnt   <= sat_inc(hit_cnt);
          if (is_rw && !hit)      miss_cnt  <= sat_inc(miss_cnt);
        end
      end

      if (clear_all) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[s] <= '0;
`ifdef DCACHE_WRITEBACK_EN
          dirty_q[s] <= '0;
`endif
          age_q[s]   <= age_init();
        end
      end else begin
        if (lru_upd) age_q[idx_q] <= lru_age;
        if (inv_hit) begin
          valid_q[idx_q][hit_way] <= 1'b0;
`ifdef DCACHE_WRITEBACK_EN
          dirty_q[idx_q][hit_way] <= 1'b0;
`endif
        end
`ifdef DCACHE_WRITEBACK_EN
        if (mark_dirty) dirty_q[idx_q][hit_way] <= 1'b1;
`endif
        if (install) begin
          valid_q[idx_q][victim_q] <= 1'b1;
`ifdef DCACHE_WRITEBACK_EN
          dirty_q[idx_q][victim_q] <= (cmd_q == CMD_WRITE);
`endif
        end
      end
    end
  end

  // Tag RAM: contents only matter once the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (!rst && install) tag_ram[idx_q][victim_q] <= tag_q;
  end

endmodule

// File: tb/tb_set_assoc_dcache_ctrl.sv
// Directed self-checking bench for set_assoc_dcache_ctrl (default parameters).
// Covers both build options via DCACHE_WRITEBACK_EN.
module tb_set_assoc_dcache_ctrl;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned OFFSET_BITS = 6;
  localparam int unsigned INDEX_BITS  = 14;
  localparam int unsigned WAYS        = 4;
  localparam int unsigned LINE_W      = ADDR_W - OFFSET_BITS;

  localparam logic [3:0] RD  = 4'd0;
  localparam logic [3:0] WR  = 4'd1;
  localparam logic [3:0] INV = 4'd3;
  localparam logic [3:0] CLR = 4'd8;
  localparam logic [3:0] PRN = 4'd9;
  localparam logic [3:0] NOP = 4'd5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [3:0]        cmd = 4'd0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic              rsp_valid, rsp_hit;
  logic              mem_req_valid, mem_req_we;
  logic [LINE_W-1:0] mem_req_addr;
  logic              mem_req_ready = 1'b1;
  logic [31:0]       hit_cnt, miss_cnt, read_cnt, write_cnt;

  int n_cmp = 0;
  int n_mis = 0;
  logic [LINE_W:0] log_q[$];

  set_assoc_dcache_ctrl #(
    .ADDR_W(ADDR_W), .OFFSET_BITS(OFFSET_BITS), .INDEX_BITS(INDEX_BITS), .WAYS(WAYS)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd), .cmd_addr(cmd_addr),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .read_cnt(read_cnt), .write_cnt(write_cnt)
  );

  always #5 clk = ~clk;

  // Record every completed next-level request as {we, line address}.
  always @(negedge clk) begin
    if (mem_req_valid && mem_req_ready) log_q.push_back({mem_req_we, mem_req_addr});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int h, input int m, input int r, input int w);
    chk({tag, "/hit_cnt"},   64'(hit_cnt),   64'(h));
    chk({tag, "/miss_cnt"},  64'(miss_cnt),  64'(m));
    chk({tag, "/read_cnt"},  64'(read_cnt),  64'(r));
    chk({tag, "/write_cnt"}, 64'(write_cnt), 64'(w));
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [LINE_W:0] exp);
    chk({tag, "/log_size"}, 64'(log_q.size() > idx), 64'd1);
    if (log_q.size() > idx) chk({tag, "/log_entry"}, 64'(log_q[idx]), 64'(exp));
  endtask

  // Issue one command at a negedge; latency counts cycles after the accept edge.
  task automatic issue(input string tag, input logic [3:0] c, input logic [31:0] a,
                       input logic exp_hit, input int exp_lat);
    int lat;
    chk({tag, "/cmd_ready"}, 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd       = c;
    cmd_addr  = a;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "/rsp_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "/latency"},   64'(lat),       64'(exp_lat));
    chk({tag, "/rsp_hit"},   64'(rsp_hit),   64'(exp_hit));
    @(negedge clk);
    chk({tag, "/rsp_pulse"},  64'(rsp_valid), 64'd0);
    chk({tag, "/ready_back"}, 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst/cmd_ready",     64'(cmd_ready),     64'd1);
    chk("rst/rsp_valid",     64'(rsp_valid),     64'd0);
    chk("rst/rsp_hit",       64'(rsp_hit),       64'd0);
    chk("rst/mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst/mem_req_we",    64'(mem_req_we),    64'd0);
    chk("rst/mem_req_addr",  64'(mem_req_addr),  64'd0);
    chk_cnt("rst", 0, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);

    // Cold read then re-read
    log_q.delete();
    issue("cold_rd", RD, 32'h0000_0040, 1'b0, 3);
    chk_log("cold_rd", 0, {1'b0, 26'h1});
    issue("re_rd", RD, 32'h0000_0040, 1'b1, 2);
    chk("re_rd/no_req", 64'(log_q.size()), 64'd1);
    chk_cnt("cold", 1, 1, 2, 0);

    // CLEAR after traffic, then no-op commands
    issue("clear1", CLR, 32'h0, 1'b0, 2);
    chk_cnt("clear1", 0, 0, 0, 0);
    issue("rd_after_clr", RD, 32'h0000_0040, 1'b0, 3);
    issue("print", PRN, 32'h0000_0040, 1'b0, 2);
    issue("nop5", NOP, 32'h0000_0040, 1'b0, 2);
    chk_cnt("noop", 0, 1, 1, 0);

    // LRU eviction in set 0
    issue("clear2", CLR, 32'h0, 1'b0, 2);
    issue("lru_t1", RD, 32'h0010_0000, 1'b0, 3);
    issue("lru_t2", RD, 32'h0020_0000, 1'b0, 3);
    issue("lru_t3", RD, 32'h0030_0000, 1'b0, 3);
    issue("lru_t4", RD, 32'h0040_0000, 1'b0, 3);
    issue("lru_t5", RD, 32'h0050_0000, 1'b0, 3);
    log_q.delete();
    issue("lru_t1_again", RD, 32'h0010_0000, 1'b0, 3);
    chk_log("lru_t1_again", 0, {1'b0, 26'h4000});
    chk_cnt("lru", 0, 6, 6, 0);
    issue("lru_t5_hit", RD, 32'h0050_0000, 1'b1, 2);
    issue("lru_t3_hit", RD, 32'h0030_0000, 1'b1, 2);
    issue("lru_t2_gone", RD, 32'h0020_0000, 1'b0, 3);
    chk_cnt("lru_end", 2, 7, 9, 0);

    // INVALIDATE
    issue("inv_rd1", RD, 32'h0000_0080, 1'b0, 3);
    issue("inv", INV, 32'h0000_0080, 1'b0, 2);
    chk_cnt("inv", 2, 8, 10, 0);
    issue("inv_rd2", RD, 32'h0000_0080, 1'b0, 3);
    chk_cnt("inv_end", 2, 9, 11, 0);

`ifdef DCACHE_WRITEBACK_EN
    // Dirty eviction
    issue("clear3", CLR, 32'h0, 1'b0, 2);
    issue("wb_w1", WR, 32'h0010_0000, 1'b0, 3);
    issue("wb_w2", WR, 32'h0020_0000, 1'b0, 3);
    issue("wb_w3", WR, 32'h0030_0000, 1'b0, 3);
    issue("wb_w4", WR, 32'h0040_0000, 1'b0, 3);
    log_q.delete();
    issue("wb_evict", RD, 32'h0050_0000, 1'b0, 4);
    chk_log("wb_evict_wr", 0, {1'b1, 26'h4000});
    chk_log("wb_evict_fill", 1, {1'b0, 26'h14000});
    issue("wb_whit", WR, 32'h0020_0000, 1'b1, 2);
    chk("wb_whit/no_req", 64'(log_q.size()), 64'd2);
    chk_cnt("wb", 1, 5, 1, 5);
`else
    // Write-through, no-write-allocate
    log_q.delete();
    issue("wt_hit", WR, 32'h0050_0000, 1'b1, 3);
    chk_log("wt_hit", 0, {1'b1, 26'h14000});
    issue("wt_miss", WR, 32'h0060_0000, 1'b0, 3);
    chk_log("wt_miss", 1, {1'b1, 26'h18000});
    issue("wt_noalloc", RD, 32'h0060_0000, 1'b0, 3);
    chk_log("wt_noalloc", 2, {1'b0, 26'h18000});
    chk_cnt("wt", 3, 11, 12, 2);
`endif

    // Stalled fill, then reset mid-FILL
    mem_req_ready = 1'b0;
    chk("stall/cmd_ready", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd       = RD;
    cmd_addr  = 32'h0000_00C0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall/mem_req_valid", 64'(mem_req_valid), 64'd1);
      chk("stall/mem_req_addr",  64'(mem_req_addr),  64'h3);
      chk("stall/mem_req_we",    64'(mem_req_we),    64'd0);
      chk("stall/cmd_ready",     64'(cmd_ready),     64'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst/mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("midrst/cmd_ready",     64'(cmd_ready),     64'd1);
    chk("midrst/rsp_valid",     64'(rsp_valid),     64'd0);
    chk_cnt("midrst", 0, 0, 0, 0);
    rst = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    issue("post_rst_rd", RD, 32'h0000_00C0, 1'b0, 3);
    chk_cnt("post_rst", 0, 1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
